// File: rtl/tick_gen_pkg.sv
// -----------------------------------------------------------------------------
// tick_gen_pkg
//
// Shared definitions for the tick_gen block and its channel sub-module.
//   MAX_CHANNELS : upper bound on the channel count (set by the cfg_sel width)
//   SEL_W        : width of the cfg_sel channel index
//   DIV_25MHZ    : 100 MHz divisor for a 25 MHz enable (VGA pixel)
//   DIV_400HZ    : 100 MHz divisor for a 400 Hz enable (keypad scan)
//   DIV_5HZ      : 100 MHz divisor for a 5 Hz enable (game step)
//   sel_hit()    : decode of a cfg_sel value against a channel index
// -----------------------------------------------------------------------------
package tick_gen_pkg;

    localparam int unsigned SEL_W        = 3;
    localparam int unsigned MAX_CHANNELS = 1 << SEL_W;

    localparam int unsigned DIV_25MHZ = 4;
    localparam int unsigned DIV_400HZ = 250000;
    localparam int unsigned DIV_5HZ   = 20000000;

    // True when the write index addresses channel idx. Indices at or above
    // the instantiated channel count never match any generated channel, so
    // writes to them fall away without extra range logic.
    function automatic logic sel_hit(input logic [SEL_W-1:0] sel,
                                     input int unsigned      idx);
        return (sel == SEL_W'(idx));
    endfunction

endpackage

// File: rtl/tick_gen_chan.sv
// -----------------------------------------------------------------------------
// tick_gen_chan
//
// One tick/phase channel: divide-by-div_act counter, shadowed divisor with a
// pending flag, registered one-cycle tick and (optionally) a square-wave phase.
//
// Optional feature macro: TICK_GEN_PHASE_EN (adds the phase output and logic).
//
// Ports:
//   clk_100M    in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   run enable for this channel
//   sync_clr    in   synchronous clear; overrides en and applies the shadow
//   wr          in   divisor write strobe already decoded for this channel
//   cfg_div     in   divisor value to load into the shadow
//   tick        out  one-cycle pulse per divisor period (registered)
//   phase       out  square wave, only with TICK_GEN_PHASE_EN
//   div_pending out  a written divisor is waiting to be applied
// -----------------------------------------------------------------------------
module tick_gen_chan #(
    parameter int unsigned       CNT_W   = 25,
    parameter logic [CNT_W-1:0]  RST_DIV = '0
)(
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             wr,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             tick,
`ifdef TICK_GEN_PHASE_EN
    output logic             phase,
`endif
    output logic             div_pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_shadow;
    logic             pend;

    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_nxt;
    logic             run;
    logic             wrap;
    logic             apply;

    always_comb begin
        run     = en && !sync_clr && (div_act != '0);
        wrap    = run && (cnt == div_act - CNT_W'(1));
        // Every edge that is not a plain mid-period count is a safe moment to
        // swap divisors: the period either just ended or is not running.
        apply   = sync_clr || !en || (div_act == '0) || wrap;

        cnt_nxt = cnt;
        if (sync_clr || (div_act == '0)) begin
            cnt_nxt = '0;
        end else if (en) begin
            cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
        end

        // The shadow copied here is the value before any write on this edge,
        // so a write colliding with an apply waits for the next opportunity.
        div_nxt = apply ? div_shadow : div_act;
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            div_act    <= RST_DIV;
            div_shadow <= RST_DIV;
            pend       <= 1'b0;
            tick       <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            div_act <= div_nxt;
            tick    <= wrap;
            if (wr) begin
                div_shadow <= cfg_div;
            end
            pend <= wr || (pend && !apply);
        end
    end

    assign div_pending = pend;

`ifdef TICK_GEN_PHASE_EN
    // Phase tracks the counter value it will sit beside after this edge,
    // measured against the divisor in force for that cycle. div_nxt >> 1 is
    // zero for divisors 0 and 1, which keeps phase low there.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 1'b0;
        end else if (sync_clr) begin
            phase <= 1'b0;
        end else if (en) begin
            phase <= (cnt_nxt < (div_nxt >> 1));
        end
    end
`endif

endmodule

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//
// Multi-channel tick and phase generator on the 100 MHz board clock. Each
// channel emits a one-cycle clock enable (tick) at a runtime-programmable
// divisor; consumers stay on clk_100M and qualify on tick.
//
// Optional feature macro: TICK_GEN_PHASE_EN (adds the per-channel phase output).
//
// Parameters:
//   CHANNELS  number of channels, 1..MAX_CHANNELS
//   CNT_W     counter / divisor width
//   DIV_INIT  packed reset divisors, channel 0 in the LSBs
//
// Ports:
//   clk_100M    in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   per-channel run enable
//   sync_clr    in   synchronous clear of all channel counters
//   cfg_wr      in   divisor write strobe, one cycle
//   cfg_sel     in   target channel index (out-of-range writes are ignored)
//   cfg_div     in   new divisor value
//   tick        out  per-channel one-cycle pulse per divisor period
//   phase       out  per-channel square wave, only with TICK_GEN_PHASE_EN
//   div_pending out  per-channel: a written divisor awaits application
// -----------------------------------------------------------------------------
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int unsigned                CHANNELS = 3,
    parameter int unsigned                CNT_W    = 25,
    parameter logic [CHANNELS*CNT_W-1:0]  DIV_INIT = {CNT_W'(DIV_5HZ),
                                                      CNT_W'(DIV_400HZ),
                                                      CNT_W'(DIV_25MHZ)}
)(
    input  logic                clk_100M,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync_clr,
    input  logic                cfg_wr,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [CNT_W-1:0]    cfg_div,
    output logic [CHANNELS-1:0] tick,
`ifdef TICK_GEN_PHASE_EN
    output logic [CHANNELS-1:0] phase,
`endif
    output logic [CHANNELS-1:0] div_pending
);

    logic [CHANNELS-1:0] wr_stb;

    always_comb begin
        wr_stb = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_stb[i] = cfg_wr && sel_hit(cfg_sel, i);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        tick_gen_chan #(
            .CNT_W   (CNT_W),
            .RST_DIV (DIV_INIT[g*CNT_W +: CNT_W])
        ) u_chan (
            .clk_100M    (clk_100M),
            .rst_n       (rst_n),
            .en          (en[g]),
            .sync_clr    (sync_clr),
            .wr          (wr_stb[g]),
            .cfg_div     (cfg_div),
            .tick        (tick[g]),
`ifdef TICK_GEN_PHASE_EN
            .phase       (phase[g]),
`endif
            .div_pending (div_pending[g])
        );
    end

endmodule

// File: tb/tb_tick_gen.sv
module tb_tick_gen;

    localparam int CH = 3;
    localparam int W  = 25;
    localparam logic [CH*W-1:0] INIT = {25'd20000000, 25'd250000, 25'd4};

    logic          clk_100M = 1'b0;
    logic          rst_n;
    logic [CH-1:0] en;
    logic          sync_clr;
    logic          cfg_wr;
    logic [2:0]    cfg_sel;
    logic [W-1:0]  cfg_div;
    logic [CH-1:0] tick;
    logic [CH-1:0] div_pending;
`ifdef TICK_GEN_PHASE_EN
    logic [CH-1:0] phase;
`endif

    always #5 clk_100M = ~clk_100M;

    tick_gen #(
        .CHANNELS (CH),
        .CNT_W    (W),
        .DIV_INIT (INIT)
    ) dut (
        .clk_100M    (clk_100M),
        .rst_n       (rst_n),
        .en          (en),
        .sync_clr    (sync_clr),
        .cfg_wr      (cfg_wr),
        .cfg_sel     (cfg_sel),
        .cfg_div     (cfg_div),
        .tick        (tick),
`ifdef TICK_GEN_PHASE_EN
        .phase       (phase),
`endif
        .div_pending (div_pending)
    );

    typedef struct packed {
        logic [CH-1:0] t;
        logic [CH-1:0] p;
        logic [CH-1:0] ph;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    int unsigned m_cnt [CH];
    int unsigned m_act [CH];
    int unsigned m_sh  [CH];
    bit          m_pend[CH];
    bit          m_tick[CH];
    bit          m_ph  [CH];

    task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        logic [CH*W-1:0] init_v;
        init_v = INIT;
        for (int i = 0; i < CH; i++) begin
            m_cnt[i]  = 0;
            m_act[i]  = int'(init_v[i*W +: W]);
            m_sh[i]   = m_act[i];
            m_pend[i] = 1'b0;
            m_tick[i] = 1'b0;
            m_ph[i]   = 1'b0;
        end
    endtask

    // Reference behaviour of one clock edge, evaluated with the inputs that
    // the DUT is about to sample.
    task automatic model_edge();
        exp_t e;
        for (int i = 0; i < CH; i++) begin
            bit          wr;
            bit          ap;
            bit          wrap;
            int unsigned act_n;
            wr = cfg_wr && (int'(cfg_sel) == i);
            ap = 1'b0;
            if (sync_clr) begin
                m_cnt[i] = 0; m_tick[i] = 1'b0; m_ph[i] = 1'b0; ap = 1'b1;
            end else if (!en[i]) begin
                m_tick[i] = 1'b0; ap = 1'b1;
            end else if (m_act[i] == 0) begin
                m_cnt[i] = 0; m_tick[i] = 1'b0; ap = 1'b1;
            end else begin
                wrap      = (m_cnt[i] + 1 == m_act[i]);
                m_tick[i] = wrap;
                m_cnt[i]  = wrap ? 0 : m_cnt[i] + 1;
                ap        = wrap;
            end
            act_n = ap ? m_sh[i] : m_act[i];
            if (!sync_clr && en[i]) m_ph[i] = (m_cnt[i] < act_n / 2);
            m_act[i] = act_n;
            if (wr) m_sh[i] = int'(cfg_div);
            m_pend[i] = wr || (m_pend[i] && !ap);
        end
        for (int i = 0; i < CH; i++) begin
            e.t[i]  = m_tick[i];
            e.p[i]  = m_pend[i];
            e.ph[i] = m_ph[i];
        end
        q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        @(posedge clk_100M);
        #1;
        e = q.pop_front();
        chk("sb_tick", tick, e.t);
        chk("sb_pend", div_pending, e.p);
`ifdef TICK_GEN_PHASE_EN
        chk("sb_phase", phase, e.ph);
`endif
    endtask

    task automatic wr_div(input logic [2:0] sel, input int unsigned d);
        cfg_wr  = 1'b1;
        cfg_sel = sel;
        cfg_div = W'(d);
        step();
        cfg_wr  = 1'b0;
    endtask

    task automatic clr();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        chk("clr_tick", tick, '0);
    endtask

    initial begin
        rst_n    = 1'b1;
        en       = '0;
        sync_clr = 1'b0;
        cfg_wr   = 1'b0;
        cfg_sel  = '0;
        cfg_div  = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_tick", tick, '0);
        chk("rst_pend", div_pending, '0);
`ifdef TICK_GEN_PHASE_EN
        chk("rst_phase", phase, '0);
`endif
        @(posedge clk_100M);
        #1;
        chk("rst_hold_tick", tick, '0);
        en    = '1;
        rst_n = 1'b1;
        model_reset();

        // Reset defaults: channel 0 ticks every 4 cycles, first at cycle 4
        for (int c = 1; c <= 12; c++) begin
            step();
            chkb("def_t0", tick[0], (c % 4) == 0);
            chkb("def_t1", tick[1], 1'b0);
        end

        // Runtime reprogram: div 5, write 3 while cnt=1
        wr_div(0, 5);
        clr();
        for (int r = 1; r <= 11; r++) begin
            if (r == 2) begin cfg_wr = 1'b1; cfg_sel = 0; cfg_div = W'(3); end
            step();
            cfg_wr = 1'b0;
            chkb("rep_t0", tick[0], r == 5 || r == 8 || r == 11);
            chkb("rep_pend", div_pending[0], r >= 2 && r <= 4);
        end

        // Write collides with wrap: div 4, write 7 on the wrap edge
        wr_div(0, 4);
        clr();
        for (int r = 1; r <= 15; r++) begin
            if (r == 4) begin cfg_wr = 1'b1; cfg_sel = 0; cfg_div = W'(7); end
            step();
            cfg_wr = 1'b0;
            chkb("col_t0", tick[0], r == 4 || r == 8 || r == 15);
            chkb("col_pend", div_pending[0], r >= 4 && r <= 7);
        end

        // Boundaries: div 1, then 0 (freeze), then 2 while frozen
        wr_div(0, 1);
        clr();
        for (int r = 1; r <= 5; r++) begin
            step();
            chkb("div1_t0", tick[0], 1'b1);
        end
        for (int r = 6; r <= 10; r++) begin
            if (r == 6) begin cfg_wr = 1'b1; cfg_sel = 0; cfg_div = W'(0); end
            step();
            cfg_wr = 1'b0;
            chkb("div0_t0", tick[0], r <= 7);
            chkb("div0_pend", div_pending[0], r == 6);
        end
        for (int r = 11; r <= 18; r++) begin
            if (r == 11) begin cfg_wr = 1'b1; cfg_sel = 0; cfg_div = W'(2); end
            step();
            cfg_wr = 1'b0;
            chkb("div2_t0", tick[0], r == 14 || r == 16 || r == 18);
            chkb("div2_pend", div_pending[0], r == 11);
        end
        for (int r = 19; r <= 22; r++) begin
            if (r == 19) begin cfg_wr = 1'b1; cfg_sel = 3'd5; cfg_div = W'(9); end
            step();
            cfg_wr = 1'b0;
            chk("badsel_pend", div_pending, '0);
            chkb("badsel_t0", tick[0], (r % 2) == 0);
        end

        // Clear and enable: divs 3 and 6 aligned after a mid-count clear
        wr_div(0, 3);
        wr_div(1, 6);
        clr();
        for (int r = 1; r <= 4; r++) begin
            step();
            chkb("pre_t0", tick[0], r == 3);
        end
        clr();
        for (int r = 1; r <= 12; r++) begin
            step();
            chkb("aln_t0", tick[0], (r % 3) == 0);
            chkb("aln_t1", tick[1], (r % 6) == 0);
        end
        wr_div(0, 4);
        en = 3'b110;
        for (int r = 1; r <= 10; r++) begin
            step();
            chkb("enl_t0", tick[0], 1'b0);
            chkb("enl_pend", div_pending[0], 1'b0);
        end
        en = '1;
        for (int r = 1; r <= 7; r++) begin
            step();
            chkb("enh_t0", tick[0], r == 3 || r == 7);
        end

        // Phase: div 6 then div 5
        wr_div(0, 6);
        clr();
        for (int r = 1; r <= 18; r++) begin
            step();
            chkb("d6_t0", tick[0], (r % 6) == 0);
`ifdef TICK_GEN_PHASE_EN
            chkb("d6_ph0", phase[0], (r % 6) < 3);
`endif
        end
        wr_div(0, 5);
        clr();
        for (int r = 1; r <= 15; r++) begin
            step();
            chkb("d5_t0", tick[0], (r % 5) == 0);
`ifdef TICK_GEN_PHASE_EN
            chkb("d5_ph0", phase[0], (r % 5) < 2);
`endif
        end

        // Async reset mid-period with a tick high and a write pending
        wr_div(0, 1);
        clr();
        step();
        chkb("pre_rst_t0", tick[0], 1'b1);
        wr_div(1, 7);
        chkb("pre_rst_pend1", div_pending[1], 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_tick", tick, '0);
        chk("arst_pend", div_pending, '0);
`ifdef TICK_GEN_PHASE_EN
        chk("arst_phase", phase, '0);
`endif
        @(posedge clk_100M);
        #1;
        chk("arst_hold", tick, '0);
        rst_n = 1'b1;
        model_reset();
        for (int r = 1; r <= 8; r++) begin
            step();
            chkb("post_rst_t0", tick[0], (r % 4) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
